// File: rtl/stream_sched_pkg.sv
// Shared types, default widths and the round-robin pick helper for stream_channel_scheduler.
package stream_sched_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } sched_state_e;

  localparam int unsigned DEF_N_CH      = 4;
  localparam int unsigned DEF_CH_W      = 2;
  localparam int unsigned DEF_DATA_W    = 24;
  localparam int unsigned DEF_GRANT_LEN = 5;

  // Upper bound on channel count handled by rr_pick
  localparam int unsigned MAX_CH   = 16;
  localparam int unsigned MAX_CH_W = 4;

  typedef struct packed {
    logic                found;
    logic [MAX_CH_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid searching ptr, ptr+1, ... modulo n_ch (n_ch a power of 2)
  function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0]   valid,
                                       input logic [MAX_CH_W-1:0] ptr,
                                       input int unsigned         n_ch);
    rr_pick_t            r;
    logic [MAX_CH_W-1:0] c;
    logic [MAX_CH_W-1:0] mask;
    r    = '0;
    mask = MAX_CH_W'(n_ch - 1);
    for (int i = int'(MAX_CH) - 1; i >= 0; i--) begin
      c = (ptr + MAX_CH_W'(i)) & mask;
      if ((i < int'(n_ch)) && valid[c]) begin
        r.found = 1'b1;
        r.idx   = c;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority rotate: grants the first requester at or after i_ptr.
module rr_arbiter
  import stream_sched_pkg::*;
#(
  parameter int unsigned N_CH = DEF_N_CH,
  parameter int unsigned CH_W = DEF_CH_W
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [CH_W-1:0] i_ptr,
  output logic            o_found,
  output logic [CH_W-1:0] o_idx,
  output logic [N_CH-1:0] o_grant
);

  rr_pick_t w_pick;

  always_comb begin
    w_pick  = rr_pick(MAX_CH'(i_req), MAX_CH_W'(i_ptr), N_CH);
    o_found = w_pick.found;
    o_idx   = CH_W'(w_pick.idx);
    o_grant = N_CH'(MAX_CH'(w_pick.found) << w_pick.idx);
  end

endmodule

// File: rtl/stream_channel_scheduler.sv
// Round-robin burst scheduler merging N_CH AXI-Stream sources into one channel-tagged stream.
// Optional per-channel enable mask via `define STREAM_SCHED_CHAN_MASK_EN.
module stream_channel_scheduler
  import stream_sched_pkg::*;
#(
  parameter int unsigned N_CH      = DEF_N_CH,
  parameter int unsigned CH_W      = DEF_CH_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned GRANT_LEN = DEF_GRANT_LEN
) (
  input  logic                   s_axis_aclk,
  input  logic                   s_axis_areset,
  input  logic [N_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [N_CH-1:0]        s_axis_tvalid,
  output logic [N_CH-1:0]        s_axis_tready,
`ifdef STREAM_SCHED_CHAN_MASK_EN
  input  logic [N_CH-1:0]        ch_enable,
`endif
  output logic [DATA_W-1:0]      m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [CH_W-1:0]        m_axis_tuser
);

  localparam int unsigned CNT_W = 4;

  sched_state_e      r_state, w_state_nxt;
  logic [CH_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [CH_W-1:0]   r_owner, w_owner_nxt;
  logic [CNT_W-1:0]  r_beat_cnt, w_beat_cnt_nxt;
  logic [N_CH-1:0]   w_en;
  logic [N_CH-1:0]   w_grant;
  logic [N_CH-1:0]   w_arb_grant;
  logic [CH_W-1:0]   w_arb_idx;
  logic              w_arb_found;
  logic [CH_W-1:0]   w_sel;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_load_ok;
  logic              w_accept;
  logic              w_owner_ok;
  logic [DATA_W-1:0] r_m_tdata;
  logic              r_m_tvalid;
  logic [CH_W-1:0]   r_m_tuser;

`ifdef STREAM_SCHED_CHAN_MASK_EN
  assign w_en = ch_enable;
`else
  assign w_en = '1;
`endif

  assign w_load_ok = !r_m_tvalid || m_axis_tready;

  rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_rr_arbiter (
    .i_req   (s_axis_tvalid & w_en),
    .i_ptr   (r_rr_ptr),
    .o_found (w_arb_found),
    .o_idx   (w_arb_idx),
    .o_grant (w_arb_grant)
  );

  // Grant selection and next-state logic
  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_beat_cnt_nxt = r_beat_cnt;
    w_grant        = '0;
    w_sel          = r_owner;
    w_owner_ok     = w_en[r_owner] && s_axis_tvalid[r_owner];

    unique case (r_state)
      ARB: begin
        w_grant = w_arb_grant;
        w_sel   = w_arb_idx;
        if (w_arb_found && w_load_ok) begin
          w_owner_nxt = w_arb_idx;
          if (GRANT_LEN == 1) begin
            w_rr_ptr_nxt = w_arb_idx + CH_W'(1);
          end else begin
            w_beat_cnt_nxt = CNT_W'(1);
            w_state_nxt    = HOLD;
          end
        end
      end
      HOLD: begin
        if (!w_owner_ok) begin
          // Owner went idle or was masked: hand the pointer on and re-arbitrate next cycle
          w_rr_ptr_nxt   = r_owner + CH_W'(1);
          w_beat_cnt_nxt = '0;
          w_state_nxt    = ARB;
        end else begin
          w_grant = N_CH'(1) << r_owner;
          if (w_load_ok) begin
            if (r_beat_cnt == CNT_W'(GRANT_LEN - 1)) begin
              w_rr_ptr_nxt   = r_owner + CH_W'(1);
              w_beat_cnt_nxt = '0;
              w_state_nxt    = ARB;
            end else begin
              w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
            end
          end
        end
      end
      default: w_state_nxt = ARB;
    endcase

    w_accept = w_load_ok && (|(w_grant & s_axis_tvalid));
  end

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (w_sel == CH_W'(k)) w_sel_data = s_axis_tdata[k*DATA_W +: DATA_W];
    end
  end

  // Disabled channels are drained (ready held high) so their beats are dropped
  assign s_axis_tready = s_axis_areset ? '0 : ((w_grant & {N_CH{w_load_ok}}) | ~w_en);

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_state    <= ARB;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tuser  <= '0;
    end else if (w_accept) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= w_sel_data;
      r_m_tuser  <= w_sel;
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tuser  = r_m_tuser;

endmodule
